// File: rtl/mc_control_if.sv
// mc_control_if: bundles the opcode/memory handshake and the datapath control
// lines of the multi-cycle MIPS main control FSM.
//
//   op, mem_ready         : from instruction decoder / memory into the FSM
//   pc_write ... pc_src   : datapath enables and mux selects from the FSM
//   state                 : current FSM state encoding
//   illegal, retire       : one-cycle status pulses
//   instr_count           : retired-instruction counter (CNT_W bits)
//
// Modports: master = control FSM side, slave = datapath/memory side.
interface mc_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_src;
  logic [3:0]       state;
  logic             illegal;
  logic             retire;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  op, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, state, illegal, retire, instr_count
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, state, illegal, retire, instr_count
  );
endinterface

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS main control FSM.
// Sequences one instruction (lw, sw, R-type, beq, addi, j) over 3-5 states,
// stalling in memory states until mem_ready, and counts retired instructions.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high (returns to FETCH, clears count)
//   bus  : mc_control_if.master -- op/mem_ready in, datapath controls,
//          state, illegal/retire pulses and instr_count out
//
// Outputs are a Moore decode of the state register, with ir_write/pc_write in
// FETCH and retire in MEMWR additionally gated by mem_ready.
module mc_control #(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  mc_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic             retire_c;

  // Output decode from the current state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_src        = 2'b00;
    bus.illegal       = 1'b0;
    retire_c          = 1'b0;

    case (state_q)
      FETCH: begin
        // PC+4 is computed every FETCH cycle but only committed together with
        // the IR load once the instruction word has arrived.
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;  // branch target precompute into ALUOut
        bus.illegal   = !(bus.op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
                                         OP_ADDI, OP_J});
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      MEMRD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        retire_c       = 1'b1;
      end
      MEMWR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        retire_c      = bus.mem_ready;
      end
      EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      ALUWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        retire_c      = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_src        = 2'b01;
        bus.pc_write_cond = 1'b1;
        retire_c          = 1'b1;
      end
      ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      ADDIWB: begin
        bus.reg_write = 1'b1;
        retire_c      = 1'b1;
      end
      JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 2'b10;
        retire_c     = 1'b1;
      end
      default: ;  // unreachable encodings: all outputs stay 0
    endcase
  end

  // State register, next-state logic and retire counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before this edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      count_q <= '0;
    end else begin
      if (retire_c) count_q <= count_q + CNT_W'(1);

      case (state_q)
        FETCH:  if (bus.mem_ready) state_q <= DECODE;
        DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state_q <= MEMADR;
            OP_RTYPE:     state_q <= EXEC;
            OP_BEQ:       state_q <= BRANCH;
            OP_ADDI:      state_q <= ADDIEX;
            OP_J:         state_q <= JUMP;
            default:      state_q <= FETCH;
          endcase
        end
        // op is still the IR's opcode here, so it selects load vs store.
        MEMADR: state_q <= (bus.op == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  if (bus.mem_ready) state_q <= MEMWB;
        MEMWB:  state_q <= FETCH;
        MEMWR:  if (bus.mem_ready) state_q <= FETCH;
        EXEC:   state_q <= ALUWB;
        ALUWB:  state_q <= FETCH;
        BRANCH: state_q <= FETCH;
        ADDIEX: state_q <= ADDIWB;
        ADDIWB: state_q <= FETCH;
        JUMP:   state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end

  assign bus.state       = state_q;
  assign bus.retire      = retire_c;
  assign bus.instr_count = count_q;

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle MIPS main control FSM, directly downstream of the instruction field decoder.
- Consumes the decoded op field and sequences one instruction over 3-5 states.
- Drives the datapath enables and muxes: PC, instruction register, memory, register file, ALU.
- Stalls on memory states until memory signals ready; counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter instr_count (wraps modulo 2^CNT_W)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous reset, active-high
op  input  6  opcode field from decoder (instr[31:26] of IR)
mem_ready  input  1  memory access complete this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (beq)
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  instruction register load
mem_to_reg  output  1  regfile write data: 0 = ALUOut, 1 = MDR
reg_dst  output  1  regfile write address: 0 = rt, 1 = rd
reg_write  output  1  regfile write enable
alu_src_a  output  1  0 = PC, 1 = A register
alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm16, 11 = sign-extended imm16 shifted left 2
alu_op  output  2  00 = add, 01 = subtract, 10 = use func field
pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
state  output  4  current state encoding
illegal  output  1  one-cycle pulse: unsupported opcode seen in DECODE
retire  output  1  one-cycle pulse: instruction completed
instr_count  output  CNT_W  count of retired instructions

Behaviour:
- Reset: on rising clk with rst=1, go to state FETCH and clear instr_count to 0. rst overrides everything, including mid-instruction and mid-stall.
- Output timing: outputs are decoded combinationally from state (Moore), except where gated by mem_ready. Any output not listed for a state is 0.
- Values directly after reset are therefore the FETCH values with mem_ready gating; illegal, retire and instr_count are 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12-15 are unreachable; if entered, go to FETCH next cycle with all outputs 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write=mem_ready, pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by op: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other op -> FETCH, with illegal=1 for this DECODE cycle. No retire and no count for an illegal opcode.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD for lw, MEMWR for sw. Uses the op value held stable by the IR.
- MEMRD: mem_read=1, i_or_d=1. Holds while mem_ready=0; goes to MEMWB when mem_ready=1.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEMWR: mem_write=1, i_or_d=1. Holds while mem_ready=0; goes to FETCH when mem_ready=1.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write_cond=1. Goes to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- JUMP: pc_write=1, pc_src=10. Goes to FETCH.
- Retire:
  - retire=1 combinationally in the final cycle of an instruction: MEMWB; MEMWR with mem_ready=1; ALUWB; BRANCH; ADDIWB; JUMP.
  - instr_count increments by 1 at the same clock edge; wraps from all-ones to 0.
  - If rst=1 in that cycle, the count clears instead (reset wins).
- Cycle counts with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Test Plan:
- Reset mid-stall: enter MEMRD, hold mem_ready=0, assert rst -> next cycle state=0, instr_count=0, mem_read=1, i_or_d=0, ir_write=0.
- lw, op=100011, mem_ready=1 -> state sequence 0,1,2,3,4,0; in state 4 reg_write=1, mem_to_reg=1, retire=1; instr_count 0->1.
- sw with mem_ready low for 3 cycles in MEMWR -> state 5 held 4 cycles with mem_write=1; retire only on the cycle mem_ready=1.
- R-type, addi, beq, j back-to-back -> sequences 0,1,6,7 / 0,1,9,10 / 0,1,8 / 0,1,11; BRANCH has pc_write_cond=1, pc_src=01; JUMP has pc_write=1, pc_src=10; instr_count=4.
- Illegal op=111111 -> illegal=1 in DECODE, next state=0, retire=0, instr_count unchanged.
- CNT_W=4, run 16 R-type instructions -> instr_count wraps 15->0.
